// File: rtl/rx_byte_fifo_if.sv
// Bundle of the receiver-side byte strobe, consumer pop port and status outputs
// of rx_byte_fifo. The master modport belongs to the environment driving the FIFO.
interface rx_byte_fifo_if #(
    parameter int AW = 3
);
    logic [7:0]  PDin;
    logic        PDready;
    logic        ParErr;
    logic        RdEn;
    logic        ClrFlags;
    logic [7:0]  Dout;
    logic        DErr;
    logic        Empty;
    logic        Full;
    logic [AW:0] Count;
    logic        Overflow;
    logic [7:0]  ErrCnt;

    modport master (
        output PDin, PDready, ParErr, RdEn, ClrFlags,
        input  Dout, DErr, Empty, Full, Count, Overflow, ErrCnt
    );

    modport slave (
        input  PDin, PDready, ParErr, RdEn, ClrFlags,
        output Dout, DErr, Empty, Full, Count, Overflow, ErrCnt
    );
endinterface

// File: rtl/rx_byte_fifo.sv
// Show-ahead byte FIFO behind the serial receiver: one write per PDready rising
// edge, registered head output, sticky overflow and saturating parity-error count.
module rx_byte_fifo #(
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter bit DROP_BAD = 1'b0
) (
    input logic           Clk,
    input logic           Rst,
    rx_byte_fifo_if.slave bus
);
    logic [8:0]    mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pdready_q;
    logic [8:0]    head_q, head_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    errcnt_q, errcnt_d;

    logic wr_evt, bad_evt, store, store_ok, pop, ovf_evt, empty, full;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        wr_evt   = bus.PDready & ~pdready_q;
        bad_evt  = wr_evt & bus.ParErr;
        store    = wr_evt & ~(DROP_BAD & bus.ParErr);
        pop      = bus.RdEn & ~empty;
        store_ok = store & (~full | pop);
        ovf_evt  = store & full & ~pop;

        wptr_d = store_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;

        count_d = count_q;
        case ({store_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // The incoming byte becomes the head when it lands on the next read slot.
        head_d = '0;
        if (count_d != '0) begin
            if (store_ok && (wptr_q == rptr_d))
                head_d = {bus.ParErr, bus.PDin};
            else
                head_d = mem[rptr_d];
        end

        // A clear is applied first so a same-cycle event survives it.
        ovf_d    = (bus.ClrFlags ? 1'b0 : ovf_q) | ovf_evt;
        errcnt_d = bus.ClrFlags ? 8'd0 : errcnt_q;
        if (bad_evt && errcnt_d != 8'hFF)
            errcnt_d = errcnt_d + 8'd1;
    end

    always_ff @(posedge Clk) begin
        if (store_ok)
            mem[wptr_q] <= {bus.ParErr, bus.PDin};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            pdready_q <= 1'b0;
            head_q    <= '0;
            ovf_q     <= 1'b0;
            errcnt_q  <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            pdready_q <= bus.PDready;
            head_q    <= head_d;
            ovf_q     <= ovf_d;
            errcnt_q  <= errcnt_d;
        end
    end

    assign bus.Dout     = head_q[7:0];
    assign bus.DErr     = head_q[8];
    assign bus.Empty    = empty;
    assign bus.Full     = full;
    assign bus.Count    = count_q;
    assign bus.Overflow = ovf_q;
    assign bus.ErrCnt   = errcnt_q;
endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed bench for rx_byte_fifo: a scoreboard queue of expected head entries is
// consumed by a monitor on every pop; status outputs are checked in the main thread.
module tb_rx_byte_fifo;
    logic clk = 1'b0;
    logic Rst = 1'b1;
    always #5 clk = ~clk;

    rx_byte_fifo_if #(.AW(3)) bus0 ();
    rx_byte_fifo_if #(.AW(3)) bus1 ();

    rx_byte_fifo #(.DEPTH(8), .AW(3), .DROP_BAD(1'b0)) dut0 (.Clk(clk), .Rst(Rst), .bus(bus0));
    rx_byte_fifo #(.DEPTH(8), .AW(3), .DROP_BAD(1'b1)) dut1 (.Clk(clk), .Rst(Rst), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input bit which, input logic [7:0] d, input logic pe,
                              input logic pop, input logic clr);
        if (!which) begin
            bus0.PDin = d; bus0.ParErr = pe; bus0.PDready = 1'b1;
            bus0.RdEn = pop; bus0.ClrFlags = clr;
        end else begin
            bus1.PDin = d; bus1.ParErr = pe; bus1.PDready = 1'b1;
            bus1.RdEn = pop; bus1.ClrFlags = clr;
        end
        tick();
        bus0.PDready = 1'b0; bus0.RdEn = 1'b0; bus0.ClrFlags = 1'b0;
        bus1.PDready = 1'b0; bus1.RdEn = 1'b0; bus1.ClrFlags = 1'b0;
        tick();
    endtask

    task automatic drain(input int n);
        bus0.RdEn = 1'b1;
        repeat (n) tick();
        bus0.RdEn = 1'b0;
    endtask

    // Every pop of dut0 must present the oldest expected entry.
    always @(negedge clk) begin
        if (!Rst && bus0.RdEn && !bus0.Empty) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %0h expected none", {bus0.DErr, bus0.Dout});
            end else begin
                logic [8:0] exp;
                exp = sb.pop_front();
                $display("pop dout=%02h derr=%0b (expected %02h/%0b)",
                         bus0.Dout, bus0.DErr, exp[7:0], exp[8]);
                if ({bus0.DErr, bus0.Dout} !== exp) begin
                    n_fail++;
                    $display("FAIL pop_data: got %0h expected %0h", {bus0.DErr, bus0.Dout}, exp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus0.PDin = '0; bus0.PDready = 0; bus0.ParErr = 0; bus0.RdEn = 0; bus0.ClrFlags = 0;
        bus1.PDin = '0; bus1.PDready = 0; bus1.ParErr = 0; bus1.RdEn = 0; bus1.ClrFlags = 0;
        tick();
        Rst = 1'b0;

        // Reset state
        check("rst_count", 32'(bus0.Count), 0);
        check("rst_empty", 32'(bus0.Empty), 1);
        check("rst_full", 32'(bus0.Full), 0);
        check("rst_dout", 32'({bus0.DErr, bus0.Dout}), 0);
        check("rst_ovf", 32'(bus0.Overflow), 0);
        check("rst_errcnt", 32'(bus0.ErrCnt), 0);

        // Three bytes one frame apart, then three pops
        sb.push_back({1'b0, 8'hA5});
        write_byte(0, 8'hA5, 0, 0, 0);
        check("t1_count1", 32'(bus0.Count), 1);
        check("t1_head", 32'({bus0.DErr, bus0.Dout}), 32'h0A5);
        repeat (9) tick();
        sb.push_back({1'b0, 8'h3C});
        write_byte(0, 8'h3C, 0, 0, 0);
        check("t1_count2", 32'(bus0.Count), 2);
        repeat (9) tick();
        sb.push_back({1'b0, 8'hFF});
        write_byte(0, 8'hFF, 0, 0, 0);
        check("t1_count3", 32'(bus0.Count), 3);
        bus0.RdEn = 1'b1;
        tick(); check("t1_pop_count2", 32'(bus0.Count), 2);
        tick(); check("t1_pop_count1", 32'(bus0.Count), 1);
        tick(); check("t1_pop_count0", 32'(bus0.Count), 0);
        bus0.RdEn = 1'b0;
        check("t1_empty", 32'(bus0.Empty), 1);
        check("t1_dout_empty", 32'({bus0.DErr, bus0.Dout}), 0);

        // Long PDready pulse writes once
        bus0.PDin = 8'h55; bus0.ParErr = 0; bus0.PDready = 1'b1;
        sb.push_back({1'b0, 8'h55});
        repeat (4) tick();
        bus0.PDready = 1'b0;
        tick();
        check("t2_count", 32'(bus0.Count), 1);
        drain(1);

        // Overflow when full
        for (int i = 0; i < 8; i++) begin
            sb.push_back({1'b0, 8'(8'h10 + i)});
            write_byte(0, 8'(8'h10 + i), 0, 0, 0);
        end
        check("t3_full", 32'(bus0.Full), 1);
        check("t3_count8", 32'(bus0.Count), 8);
        write_byte(0, 8'h99, 0, 0, 0);
        check("t3_ovf", 32'(bus0.Overflow), 1);
        check("t3_full_after", 32'(bus0.Full), 1);
        check("t3_count_after", 32'(bus0.Count), 8);
        drain(8);
        check("t3_empty", 32'(bus0.Empty), 1);
        bus0.ClrFlags = 1'b1;
        tick();
        bus0.ClrFlags = 1'b0;
        check("t3_ovf_clr", 32'(bus0.Overflow), 0);

        // Store and pop together while full
        for (int i = 0; i < 8; i++) begin
            sb.push_back({1'b0, 8'(8'h20 + i)});
            write_byte(0, 8'(8'h20 + i), 0, 0, 0);
        end
        sb.push_back({1'b0, 8'h77});
        write_byte(0, 8'h77, 0, 1, 0);
        check("t4_count", 32'(bus0.Count), 8);
        check("t4_full", 32'(bus0.Full), 1);
        check("t4_ovf", 32'(bus0.Overflow), 0);
        drain(8);

        // Parity errors kept (dut0) and dropped (dut1)
        sb.push_back({1'b1, 8'h12});
        write_byte(0, 8'h12, 1, 0, 0);
        check("t5_head", 32'({bus0.DErr, bus0.Dout}), 32'h112);
        check("t5_errcnt", 32'(bus0.ErrCnt), 1);
        sb.push_back({1'b1, 8'h34});
        write_byte(0, 8'h34, 1, 0, 1);
        check("t5_clr_with_err", 32'(bus0.ErrCnt), 1);
        check("t5_count", 32'(bus0.Count), 2);
        drain(2);
        write_byte(1, 8'h12, 1, 0, 0);
        check("t5_drop_empty", 32'(bus1.Empty), 1);
        check("t5_drop_errcnt", 32'(bus1.ErrCnt), 1);
        for (int i = 0; i < 299; i++) write_byte(1, 8'h12, 1, 0, 0);
        check("t5_errcnt_sat", 32'(bus1.ErrCnt), 255);
        check("t5_drop_empty2", 32'(bus1.Empty), 1);

        // Reset with entries held; PDready high across reset release
        for (int i = 0; i < 5; i++) begin
            sb.push_back({1'b0, 8'(8'h40 + i)});
            write_byte(0, 8'(8'h40 + i), 0, 0, 0);
        end
        check("t6_count5", 32'(bus0.Count), 5);
        Rst = 1'b1;
        bus0.PDin = 8'h66; bus0.ParErr = 0; bus0.PDready = 1'b1;
        tick();
        check("t6_count", 32'(bus0.Count), 0);
        check("t6_empty", 32'(bus0.Empty), 1);
        check("t6_dout", 32'({bus0.DErr, bus0.Dout}), 0);
        check("t6_ovf", 32'(bus0.Overflow), 0);
        check("t6_errcnt", 32'(bus0.ErrCnt), 0);
        sb.delete();
        Rst = 1'b0;
        sb.push_back({1'b0, 8'h66});
        tick();
        bus0.PDready = 1'b0;
        check("t6_edge_count", 32'(bus0.Count), 1);
        check("t6_edge_head", 32'({bus0.DErr, bus0.Dout}), 32'h066);
        tick();
        drain(1);
        tick();

        check("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
